// File: rtl/wb_regfile_scoreboard.sv
// Writeback receiver: commits results to the architectural register file,
// serves two bypassed decode read ports, and keeps a per-register count of
// in-flight writes so decode can be stalled on read-after-write hazards.
module wb_regfile_scoreboard #(
  parameter int DATA_W  = 10,
  parameter int NREGS   = 4,
  parameter int ADDR_W  = 2,
  parameter int MAXPEND = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_en_in,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] rd_issue,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic [NREGS-1:0]  pending,
  output logic              wb_error
);

  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXPEND);

  logic [DATA_W-1:0] regs [NREGS];
  logic [CNT_W-1:0]  cnt  [NREGS];

  logic             wb_live;     // writeback actually takes effect this cycle
  logic             wb_commit;   // writeback to a real (non-r0) register
  logic             bypass_rs;
  logic             bypass_rt;
  logic             hazard_rs;
  logic             hazard_rt;
  logic             dest_full;
  logic [NREGS-1:0] inc;
  logic [NREGS-1:0] dec;

  assign wb_live   = PC_en_in & wb_valid;
  assign wb_commit = wb_live & (wb_addr != '0);
  assign bypass_rs = wb_live & (wb_addr == rs_addr);
  assign bypass_rt = wb_live & (wb_addr == rt_addr);

  // Read ports: r0 is hard zero, a same-cycle writeback wins over the array.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    rs_data = regs[rs_addr];
    rt_data = regs[rt_addr];
    if (bypass_rs) rs_data = wb_data;
    if (bypass_rt) rt_data = wb_data;
    if (rs_addr == '0) rs_data = '0;
    if (rt_addr == '0) rt_data = '0;
  end

  // Scoreboard decisions: retire/issue per register, hazards and stall.
  always_comb begin
    dec = '0;
    inc = '0;
    for (int i = 1; i < NREGS; i++) begin
      dec[i] = wb_live & (wb_addr == ADDR_W'(i)) & (cnt[i] != '0);
    end
    // A source is safe only if its sole outstanding write is landing right now.
    hazard_rs = (rs_addr != '0) && (cnt[rs_addr] != '0) &&
                !((cnt[rs_addr] == CNT_W'(1)) && bypass_rs);
    hazard_rt = (rt_addr != '0) && (cnt[rt_addr] != '0) &&
                !((cnt[rt_addr] == CNT_W'(1)) && bypass_rt);
    // Counter saturation blocks a further issue unless one retires this cycle.
    dest_full = (rd_issue != '0) && (cnt[rd_issue] == CNT_MAX) && !dec[rd_issue];
    stall     = issue_valid & (hazard_rs | hazard_rt | dest_full);
    for (int i = 1; i < NREGS; i++) begin
      inc[i] = issue_valid & ~stall & (rd_issue == ADDR_W'(i));
    end
  end

  // Pending flags mirror non-zero counters; r0 never has writes in flight.
  always_comb begin
    pending = '0;
    for (int i = 1; i < NREGS; i++) begin
      pending[i] = (cnt[i] != '0);
    end
  end

  // State update: register commit, counter tracking and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      // NOTE: the register array is reset explicitly because reads after reset must return zero.
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      wb_error <= 1'b0;
    end else if (PC_en_in) begin
      if (wb_commit) begin
        regs[wb_addr] <= wb_data;
        if (cnt[wb_addr] == '0) wb_error <= 1'b1;
      end
      for (int i = 1; i < NREGS; i++) begin
        if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - CNT_W'(1);
      end
    end
  end

endmodule
